// File: rtl/spi_master_ctrl_pkg.sv
// spi_master_ctrl_pkg
//   Shared definitions for the SPI master slice: controller state encoding,
//   SPI mode constants (only mode 0 is implemented today) and a small
//   elaboration-time helper.
package spi_master_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } spi_state_t;

    // {CPOL, CPHA} encodings kept for future mode support.
    typedef enum logic [1:0] {
        SPI_MODE0 = 2'b00,
        SPI_MODE1 = 2'b01,
        SPI_MODE2 = 2'b10,
        SPI_MODE3 = 2'b11
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE_DEFAULT = SPI_MODE0;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_master_ctrl_sclk_generator.sv
// sclk_generator
//   Free-running SPI clock divider. While sclk_en is high, sclk toggles every
//   H = MASTER_FREQ/(2*SLAVE_FREQ) clk cycles, first rising H cycles after
//   enable. While sclk_en is low, sclk is held low and the divider is cleared.
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   sclk_en  in   run the divider
//   sclk     out  SPI clock, idles low
module sclk_generator #(
    parameter int MASTER_FREQ = 100_000_000,
    parameter int SLAVE_FREQ  = 1_800_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk_en,
    output logic sclk
);

    localparam int HALF = MASTER_FREQ / (2 * SLAVE_FREQ);
    localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!sclk_en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (cnt == CW'(HALF - 1)) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl
//   SPI mode-0 transaction sequencer. A start/busy/done handshake turns one
//   DATA_W-bit word into a full-duplex transfer: cs_n setup, DATA_W sclk
//   periods (MOSI shifted MSB first, MISO captured on rising sclk), cs_n hold.
// Ports
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   start    in   transfer request, sampled only while idle
//   tx_data  in   word to send, latched on accepted start
//   busy     out  transfer in progress
//   done     out  one-cycle completion pulse
//   rx_data  out  last received word, valid from done
//   sclk     out  SPI clock (idles low)
//   mosi     out  serial data out
//   miso     in   serial data in (asynchronous, synchronised here)
//   cs_n     out  active-low chip select
module spi_master_ctrl
    import spi_master_ctrl_pkg::*;
#(
    parameter int MASTER_FREQ = 100_000_000,
    parameter int SLAVE_FREQ  = 1_800_000,
    parameter int DATA_W      = 8,
    parameter int CS_SETUP    = 4,
    parameter int CS_HOLD     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int CS_MAX = max_int(CS_SETUP, CS_HOLD);
    localparam int CNT_W  = $clog2(CS_MAX + 1);
    localparam int BIT_W  = $clog2(DATA_W + 1);

    spi_state_t state, state_nx;

    logic [CNT_W-1:0]  cs_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic              sclk_en;
    logic              sclk_d;
    logic              miso_meta;
    logic              miso_sync;
    logic              rise;
    logic              fall;
    logic              accept;
    logic              setup_last;
    logic              xfer_last;
    logic              hold_last;

    sclk_generator #(
        .MASTER_FREQ (MASTER_FREQ),
        .SLAVE_FREQ  (SLAVE_FREQ)
    ) u_sclk_gen (
        .clk     (clk),
        .rst     (rst),
        .sclk_en (sclk_en),
        .sclk    (sclk)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        setup_last = 1'b0;
        xfer_last  = 1'b0;
        hold_last  = 1'b0;
        rise       = sclk & ~sclk_d;
        fall       = ~sclk & sclk_d;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cs_cnt == CNT_W'(CS_SETUP - 1)) begin
                    setup_last = 1'b1;
                    state_nx   = ST_XFER;
                end
            end
            ST_XFER: begin
                // The fall after the last rise ends the bit phase; sclk is
                // already low here, so dropping sclk_en leaves it parked low.
                if (fall && bit_cnt == BIT_W'(DATA_W)) begin
                    xfer_last = 1'b1;
                    state_nx  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (cs_cnt == CNT_W'(CS_HOLD - 1)) begin
                    hold_last = 1'b1;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_cnt    <= '0;
            bit_cnt   <= '0;
            tx_sh     <= '0;
            rx_sh     <= '0;
            rx_data   <= '0;
            sclk_en   <= 1'b0;
            sclk_d    <= 1'b0;
            miso_meta <= 1'b0;
            miso_sync <= 1'b0;
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            mosi      <= 1'b0;
        end else begin
            done      <= 1'b0;
            sclk_d    <= sclk;
            miso_meta <= miso;
            miso_sync <= miso_meta;

            if (accept) begin
                tx_sh   <= tx_data;
                rx_sh   <= '0;
                bit_cnt <= '0;
                cs_cnt  <= '0;
                cs_n    <= 1'b0;
                busy    <= 1'b1;
                mosi    <= tx_data[DATA_W-1];
            end

            if (state == ST_SETUP) begin
                cs_cnt <= setup_last ? '0 : cs_cnt + 1'b1;
            end
            if (setup_last) sclk_en <= 1'b1;

            if (state == ST_XFER) begin
                if (rise) begin
                    rx_sh   <= {rx_sh[DATA_W-2:0], miso_sync};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (fall && !xfer_last) begin
                    tx_sh <= {tx_sh[DATA_W-2:0], 1'b0};
                    mosi  <= tx_sh[DATA_W-2];
                end
                if (xfer_last) sclk_en <= 1'b0;
            end

            if (state == ST_HOLD) cs_cnt <= cs_cnt + 1'b1;

            if (hold_last) begin
                cs_cnt  <= '0;
                cs_n    <= 1'b1;
                rx_data <= rx_sh;
                done    <= 1'b1;
                busy    <= 1'b0;
                mosi    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl
//   Self-checking bench for spi_master_ctrl: an 8-bit and a 16-bit instance,
//   driven with fixed and random words, against a transaction-level SPI slave
//   model (loopback or shifting a random word out on falling sclk).
module tb_spi_master_ctrl;

    localparam int H    = 100_000_000 / (2 * 1_800_000);
    localparam int CS_S = 4;
    localparam int CS_H = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start8, start16;
    logic [7:0]  tx8, rx8;
    logic [15:0] tx16, rx16;
    logic        busy8, done8, sclk8, mosi8, miso8, cs8;
    logic        busy16, done16, sclk16, mosi16, miso16, cs16;
    logic        slave_bit;
    logic        loop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign miso8  = loop ? mosi8  : slave_bit;
    assign miso16 = loop ? mosi16 : slave_bit;

    spi_master_ctrl #(
        .MASTER_FREQ (100_000_000),
        .SLAVE_FREQ  (1_800_000),
        .DATA_W      (8),
        .CS_SETUP    (CS_S),
        .CS_HOLD     (CS_H)
    ) u8 (
        .clk (clk), .rst (rst), .start (start8), .tx_data (tx8),
        .busy (busy8), .done (done8), .rx_data (rx8), .sclk (sclk8),
        .mosi (mosi8), .miso (miso8), .cs_n (cs8)
    );

    spi_master_ctrl #(
        .MASTER_FREQ (100_000_000),
        .SLAVE_FREQ  (1_800_000),
        .DATA_W      (16),
        .CS_SETUP    (CS_S),
        .CS_HOLD     (CS_H)
    ) u16 (
        .clk (clk), .rst (rst), .start (start16), .tx_data (tx16),
        .busy (busy16), .done (done16), .rx_data (rx16), .sclk (sclk16),
        .mosi (mosi16), .miso (miso16), .cs_n (cs16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_start(input bit sel, input logic v);
        if (sel) start16 = v;
        else     start8  = v;
    endtask

    task automatic sample(input bit sel, output logic cs, output logic sc, output logic mo,
                          output logic dn, output logic bz, output logic [31:0] rx);
        if (sel) begin
            cs = cs16; sc = sclk16; mo = mosi16; dn = done16; bz = busy16; rx = {16'h0, rx16};
        end else begin
            cs = cs8;  sc = sclk8;  mo = mosi8;  dn = done8;  bz = busy8;  rx = {24'h0, rx8};
        end
    endtask

    task automatic launch(input bit sel, input logic [31:0] tx);
        @(negedge clk);
        if (sel) tx16 = tx[15:0];
        else     tx8  = tx[7:0];
        set_start(sel, 1'b1);
    endtask

    // Observes one transfer from the cycle after acceptance up to its done
    // pulse. hold keeps start high throughout; poke_at>0 fires a second start
    // with a different tx word after that many sclk rises.
    task automatic monitor(input bit sel, input int unsigned w, input logic [31:0] tx,
                           input logic [31:0] sw, input bit hold, input int unsigned poke_at);
        logic cs, sc, mo, dn, bz, prev_sc, prev_bc;
        logic [31:0] rx, mosi_word, exp_rx, mask;
        int unsigned rises, last_rise, bad_gap, cs_low, busy_low, idx, bc_hits, poke_cyc, exp_low;
        bit mosi_hi, got_done, poked;

        mask      = 32'((64'd1 << w) - 1);
        mosi_word = '0;
        prev_sc   = 1'b0;
        prev_bc   = 1'b0;
        rises = 0; last_rise = 0; bad_gap = 0; cs_low = 0; busy_low = 0; bc_hits = 0;
        poke_cyc = 0;
        mosi_hi = 0; got_done = 0; poked = 0;
        cs = 1'b1; bz = 1'b0; rx = '0;
        idx = w - 1;
        slave_bit = sw[idx];

        for (int unsigned cyc = 0; cyc < 4000 && !got_done; cyc++) begin
            @(negedge clk);
            sample(sel, cs, sc, mo, dn, bz, rx);
            if (cyc == 0) begin
                check("cs_first_low", {31'h0, cs}, 32'h0);
                if (!hold) set_start(sel, 1'b0);
            end
            if (poked && cyc == poke_cyc + 1 && !hold) set_start(sel, 1'b0);
            if (poke_at != 0 && !poked && rises == poke_at) begin
                poked    = 1;
                poke_cyc = cyc;
                if (sel) tx16 = ~tx[15:0] ^ 16'($urandom_range(1, 255));
                else     tx8  = ~tx[7:0];
                set_start(sel, 1'b1);
            end
            if (sc && !prev_sc) begin
                if (rises > 0 && cyc - last_rise != 2 * H) bad_gap++;
                last_rise = cyc;
                rises++;
                mosi_word = {mosi_word[30:0], mo};
            end
            if (!sc && prev_sc && idx > 0) begin
                idx--;
                slave_bit = sw[idx];
            end
            prev_sc = sc;
            if (mo) mosi_hi = 1;
            if (sel) begin
                if (u16.bit_cnt == 5'd16 && !prev_bc) bc_hits++;
                prev_bc = (u16.bit_cnt == 5'd16);
            end
            if (dn) got_done = 1;
            else begin
                if (!cs) cs_low++;
                if (!bz) busy_low++;
            end
        end

        exp_rx  = loop ? (tx & mask) : (sw & mask);
        exp_low = CS_S + 2 * w * H + CS_H;
        check("done_seen",     {31'h0, got_done}, 32'h1);
        check("rx_data",       rx, exp_rx);
        check("mosi_word",     mosi_word & mask, tx & mask);
        check("sclk_rises",    rises, w);
        check("rise_spacing",  bad_gap, 0);
        check("busy_held",     busy_low, 0);
        check("busy_at_done",  {31'h0, bz}, 32'h0);
        check("cs_at_done",    {31'h0, cs}, 32'h1);
        check("mosi_activity", {31'h0, mosi_hi}, {31'h0, ((tx & mask) != 0)});
        check("cs_low_time",   {31'h0, (cs_low + 2 >= exp_low && cs_low <= exp_low + 2)}, 32'h1);
        if (sel) check("bit_cnt_full_once", bc_hits, 1);
        if (!hold) begin
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                sample(sel, cs, sc, mo, dn, bz, rx);
                check("idle_after", {29'h0, dn, cs, sc}, {29'h0, 1'b0, 1'b1, 1'b0});
            end
        end
    endtask

    initial begin
        logic [31:0] t1, t2;
        int unsigned r;
        bit dn_seen, prev;

        rst = 1'b1; start8 = 1'b0; start16 = 1'b0; tx8 = '0; tx16 = '0;
        loop = 1'b0; slave_bit = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_out8",  {26'h0, cs8, sclk8, mosi8, busy8, done8, 1'b0}, {26'h0, 6'b100000});
        check("reset_rx8",   {24'h0, rx8}, 32'h0);
        check("reset_out16", {27'h0, cs16, sclk16, mosi16, busy16, done16}, {27'h0, 5'b10000});
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Loopback of a fixed pattern.
        loop = 1'b1;
        launch(0, 32'hA5);
        monitor(0, 8, 32'hA5, 32'h0, 0, 0);

        // All-zero word out, slave returns all ones.
        loop = 1'b0;
        launch(0, 32'h00);
        monitor(0, 8, 32'h00, 32'hFF, 0, 0);

        // Random words, random loopback/slave mode.
        for (int i = 0; i < 6; i++) begin
            loop = 1'($urandom_range(0, 1));
            t1 = 32'($urandom_range(0, 255));
            t2 = 32'($urandom_range(0, 255));
            launch(0, t1);
            monitor(0, 8, t1, t2, 0, 0);
        end

        // Reset after the third sclk rise.
        loop = 1'b1;
        launch(0, 32'h3C);
        r = 0; prev = 0;
        for (int c = 0; c < 2000 && r < 3; c++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (sclk8 && !prev) r++;
            prev = sclk8;
        end
        check("rst_reached_rise3", r, 3);
        rst = 1'b1;
        #1;
        check("rst_mid_out", {27'h0, cs8, sclk8, busy8, done8, mosi8}, {27'h0, 5'b10000});
        check("rst_mid_rx",  {24'h0, rx8}, 32'h0);
        dn_seen = 0;
        repeat (4) @(negedge clk) if (done8) dn_seen = 1;
        rst = 1'b0;
        repeat (60) @(negedge clk) if (done8 || !cs8 || sclk8) dn_seen = 1;
        check("rst_mid_quiet", {31'h0, dn_seen}, 32'h0);

        // Back-to-back: start held high through the first done.
        loop = 1'b1;
        t1 = 32'($urandom_range(1, 255));
        t2 = 32'($urandom_range(1, 255));
        launch(0, t1);
        monitor(0, 8, t1, 32'h0, 1, 0);
        tx8 = t2[7:0];
        monitor(0, 8, t2, 32'h0, 0, 0);

        // Start with a different tx word while busy is ignored.
        t1 = 32'($urandom_range(0, 255));
        launch(0, t1);
        monitor(0, 8, t1, 32'h0, 0, 3);

        // 16-bit instance.
        loop = 1'b1;
        launch(1, 32'h8001);
        monitor(1, 16, 32'h8001, 32'h0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            loop = 1'($urandom_range(0, 1));
            t1 = 32'($urandom_range(0, 65535));
            t2 = 32'($urandom_range(0, 65535));
            launch(1, t1);
            monitor(1, 16, t1, t2, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
